// File: rtl/mcpu_pkg.sv
// Shared types and constants for the GPR write path.
package mcpu_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One pending GPR write: destination register and data.
  typedef struct packed {
    logic [REG_AW-1:0] rw;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

  // Which source owns the GPR write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } wr_src_e;

  // r0 is hardwired to zero and never tracked or written.
  function automatic logic is_reg_zero(input logic [REG_AW-1:0] r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback-stage signals around the GPR write arbiter.
interface wb_arbiter_if;
  import mcpu_pkg::*;

  // pipeline writeback
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rw;
  logic [DATA_W-1:0] wb_wd;
  // md dispatch notification from ID
  logic              md_issue;
  logic [REG_AW-1:0] md_issue_rw;
  // md result handshake
  logic              md_valid;
  logic [REG_AW-1:0] md_rw;
  logic [DATA_W-1:0] md_wd;
  logic              md_ready;
  // ID hazard lookup
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              busy_rs;
  logic              busy_rt;
  logic              busy_rd;
  // GPR write port
  logic              regWrite;
  logic [REG_AW-1:0] rw;
  logic [DATA_W-1:0] Wd;

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_rw, wb_wd,
    input  md_issue, md_issue_rw,
    input  md_valid, md_rw, md_wd,
    output md_ready,
    input  rs, rt, rd,
    output busy_rs, busy_rt, busy_rd,
    output regWrite, rw, Wd
  );

  // Surrounding pipeline side.
  modport master (
    output wb_valid, wb_rw, wb_wd,
    output md_issue, md_issue_rw,
    output md_valid, md_rw, md_wd,
    input  md_ready,
    output rs, rt, rd,
    input  busy_rs, busy_rt, busy_rd,
    input  regWrite, rw, Wd
  );

endinterface

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO; head is visible combinationally.
module wb_fifo
  import mcpu_pkg::*;
#(
  parameter int  DEPTH     = 2,
  parameter type payload_t = wb_req_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  payload_t                     push_data,
  output payload_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  payload_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  // Ignore a push into a full FIFO or a pop from an empty one.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/wb_arbiter.sv
// GPR write-port arbiter: pipeline writeback first, then queued md results,
// then md bypass; keeps a pending-write scoreboard for ID hazard stalls.
module wb_arbiter
  import mcpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH+1);

  wb_req_t         md_req;
  wb_req_t         head;
  wb_req_t         wr_req;
  wr_src_e         src;
  logic            full;
  logic            empty;
  logic [CW-1:0]   fifo_count;
  logic            md_ready_int;
  logic            md_xfer;
  logic            push;
  logic            pop;
  logic            md_wr;
  logic [NREG-1:0] sb_reg;
  logic [NREG-1:0] sb_next;

  // Readiness depends only on stored occupancy, never on a same-cycle pop.
  assign md_ready_int = (fifo_count < CW'(DEPTH));
  assign bus.md_ready = md_ready_int;
  assign md_xfer      = bus.md_valid && md_ready_int;
  assign md_req       = '{rw: bus.md_rw, wd: bus.md_wd};

  // Pick the write-port owner for this cycle, highest priority first.
  always_comb begin
    src    = SRC_NONE;
    wr_req = '0;
    if (bus.wb_valid) begin
      src    = SRC_WB;
      wr_req = '{rw: bus.wb_rw, wd: bus.wb_wd};
    end else if (!empty) begin
      src    = SRC_FIFO;
      wr_req = head;
    end else if (bus.md_valid) begin
      src    = SRC_BYP;
      wr_req = md_req;
    end
  end

  // A bypassed result is consumed directly and never stored.
  assign push  = md_xfer && (src != SRC_BYP);
  assign pop   = (src == SRC_FIFO);
  assign md_wr = (src == SRC_FIFO) || (src == SRC_BYP);

  assign bus.regWrite = !reset && (src != SRC_NONE) && !is_reg_zero(wr_req.rw);
  assign bus.rw       = wr_req.rw;
  assign bus.Wd       = wr_req.wd;

  wb_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (wb_req_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (md_req),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Per-register next state: an issue this cycle beats a retiring md write.
  genvar gi;
  for (gi = 0; gi < NREG; gi++) begin : g_sb
    logic set_hit;
    logic clr_hit;
    assign set_hit     = bus.md_issue && (bus.md_issue_rw == REG_AW'(gi)) && (gi != 0);
    assign clr_hit     = md_wr && (wr_req.rw == REG_AW'(gi));
    assign sb_next[gi] = set_hit | (sb_reg[gi] & ~clr_hit);
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb_reg <= '0;
    else       sb_reg <= sb_next;
  end

  // Busy reflects registered state only, so release lags the write by a cycle.
  assign bus.busy_rs = sb_reg[bus.rs] && !is_reg_zero(bus.rs);
  assign bus.busy_rt = sb_reg[bus.rt] && !is_reg_zero(bus.rt);
  assign bus.busy_rd = sb_reg[bus.rd] && !is_reg_zero(bus.rd);

  // Protocol checks: double issue, result without an issued op, overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.md_issue && !is_reg_zero(bus.md_issue_rw) && sb_reg[bus.md_issue_rw]));
      assert (!(md_xfer && !is_reg_zero(bus.md_rw) && !sb_reg[bus.md_rw]));
      assert (!(push && full));
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writer side of the GPR write port (regWrite/rw/Wd), in the WB stage.
- Merges two result sources into the single GPR write port:
  - the in-order pipeline writeback;
  - results from the multi-cycle mul/div unit (md).
- Buffers md results in a small FIFO and holds a per-register pending scoreboard so ID can stall on RAW/WAW hazards against in-flight md results.

Parameters:
- DEPTH, 2, md result FIFO entries (power of two, >=2).
- NREG, 32, architectural register count (scoreboard width).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  pipeline writeback request; never stalls.
- wb_rw  in  5  pipeline destination register.
- wb_wd  in  32  pipeline write data.
- md_issue  in  1  ID dispatched an md op this cycle.
- md_issue_rw  in  5  destination of the dispatched md op.
- md_valid  in  1  md unit presents a result.
- md_rw  in  5  md result destination.
- md_wd  in  32  md result data.
- md_ready  out  1  arbiter accepts md result this cycle.
- rs, rt, rd  in  5 each  ID-stage register addresses to check.
- busy_rs, busy_rt, busy_rd  out  1 each  register has a pending md write.
- regWrite  out  1  GPR write enable.
- rw  out  5  GPR write address.
- Wd  out  32  GPR write data.

Behaviour:
- Reset (async, active-high): FIFO count=0, rd/wr pointers=0, all scoreboard bits=0. Outputs during reset: md_ready=1, busy_*=0, regWrite=0; rw and Wd are don't-care while regWrite=0.
- Write-port select is combinational, zero latency, priority order:
  1. wb_valid: write wb_rw/wb_wd.
  2. FIFO non-empty: write FIFO head, pop at the clock edge.
  3. FIFO empty and md_valid: bypass, write md_rw/md_wd directly; the entry is never stored.
  4. Otherwise regWrite=0.
- Register 0: a selected source with address 0 is consumed or popped normally, but regWrite=0.
- md handshake: transfer occurs when md_valid && md_ready. md_ready = (count < DEPTH), registered-state only, no dependence on same-cycle pop.
- Push rule: a transferred md result enters the FIFO unless it took the bypass path that cycle.
- When full and popping, md_ready stays 0 that cycle; no full-case pass-through.
- FIFO pointers wrap modulo DEPTH. Count is updated +1 (push only), -1 (pop only), 0 (both or neither).
- Ordering: md results leave in arrival order. Pipeline writes may overtake queued md results; WAW safety is ID's job via busy_rd.
- Scoreboard set: on md_issue, set bit[md_issue_rw], except register 0.
- Scoreboard clear: when an md result (FIFO head or bypass) is written to the GPR, clear bit[that rw].
- Set and clear of the same register in one cycle: set wins.
- Issue to an already pending register is illegal. Assert in simulation; ID prevents it via busy_rd.
- busy_x = scoreboard[x] && (x != 0), combinational from current state. It does not reflect a same-cycle clear, so stall release has 1 cycle latency after the GPR write.
- Overflow: only when the md unit produces more results than issued ops. Flag with a simulation assertion; no recovery logic.

Decomposition:
- Shared package mcpu_pkg:
  - constant REG_AW=5, constant DATA_W=32.
  - typedef wb_req_t struct {rw[REG_AW], wd[DATA_W]}.
  - REG_ZERO constant.
- Sub-module wb_fifo (DEPTH, wb_req_t payload):
  - inputs push/pop, outputs full/empty/head/count.
  - Reused later for store buffers.
- Arbitration and scoreboard stay in wb_arbiter.

Test Plan:
- Reset mid-operation: 2 md results queued, 2 pending bits set; assert reset -> count=0, busy_*=0, regWrite=0 immediately, without waiting for a clock edge.
- Bypass: FIFO empty, wb_valid=0, md_valid=1, md_rw=8, md_wd=0x12345678 -> same cycle regWrite=1, rw=8, Wd=0x12345678. busy for r8 drops the next cycle; FIFO count stays 0.
- Priority and ordering:
  - wb_valid=1 held 4 cycles (rw=3).
  - md results r5=0xA, then r6=0xB arrive during that window -> queued, md_ready=0 after the second.
  - Writes occur r3 x4, then r5=0xA, then r6=0xB, in order.
- Full/pop: FIFO full, wb_valid=0 -> head written and popped; md_ready=0 that cycle and 1 the next cycle.
- Register zero: md issue and result to r0 with data 0xFFFFFFFF -> regWrite=0, busy_rs(rs=0)=0. Same for wb_rw=0.
- Scoreboard:
  - md_issue_rw=9 -> busy_rt=1 with rt=9 from the next cycle.
  - Stays 1 while the result sits queued behind wb writes.
  - Clears 1 cycle after the r9 GPR write.
